// File: rtl/bp_update_unit_pkg.sv
// Shared definitions for the branch-predictor update unit: truth constants,
// FSM state encodings and the default predictor index width.
package bp_update_unit_pkg;
    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam int DEFAULT_TAG_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;
endpackage

// File: rtl/bp_update_unit_if.sv
// Commit-side bundle: ROB commit inputs plus predictor-update, flush and
// statistics outputs of the update unit.
interface bp_update_unit_if
    import bp_update_unit_pkg::*;
#(
    parameter int TAG_W = DEFAULT_TAG_W
);
    logic             in_rob_commit_valid;
    logic             in_rob_is_branch;
    logic [31:0]      in_rob_pc;
    logic             in_rob_pred_jump;
    logic             in_rob_real_jump;
    logic [31:0]      in_rob_target_pc;
    logic             out_rob_stall;
    logic             out_bp_res;
    logic [TAG_W-1:0] out_bp_tag;
    logic             out_bp_jump_res;
    logic             out_flush;
    logic [31:0]      out_redirect_pc;
    logic [31:0]      out_branch_cnt;
    logic [31:0]      out_mispredict_cnt;

    modport master (
        output in_rob_commit_valid, in_rob_is_branch, in_rob_pc,
               in_rob_pred_jump, in_rob_real_jump, in_rob_target_pc,
        input  out_rob_stall, out_bp_res, out_bp_tag, out_bp_jump_res,
               out_flush, out_redirect_pc, out_branch_cnt, out_mispredict_cnt
    );

    modport slave (
        input  in_rob_commit_valid, in_rob_is_branch, in_rob_pc,
               in_rob_pred_jump, in_rob_real_jump, in_rob_target_pc,
        output out_rob_stall, out_bp_res, out_bp_tag, out_bp_jump_res,
               out_flush, out_redirect_pc, out_branch_cnt, out_mispredict_cnt
    );
endinterface

// File: rtl/bp_update_fifo.sv
// Parameterised synchronous FIFO holding queued predictor updates.
// Same-edge push and pop are allowed and leave the count unchanged.
module bp_update_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // NOTE: storage is deliberately not reset; count and pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // NOTE: registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/bp_update_unit.sv
// Turns committed branches into predictor updates via a small FIFO and raises
// a one-cycle flush with redirect PC on a committed misprediction.
module bp_update_unit
    import bp_update_unit_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = DEFAULT_TAG_W,
    parameter int TAG_LSB    = 2
) (
    input logic             clk,
    input logic             rst,
    input logic             rdy,
    bp_update_unit_if.slave bus
);
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_W = TAG_W + 1;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic               accept;
    logic               mispredict;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] push_data;
    logic [ENTRY_W-1:0] head;

    assign bus.out_rob_stall = (fifo_count == CNT_W'(FIFO_DEPTH)) | (state == FLUSH);

    assign accept     = rdy & bus.in_rob_commit_valid & bus.in_rob_is_branch & ~bus.out_rob_stall;
    assign mispredict = accept & (bus.in_rob_pred_jump != bus.in_rob_real_jump);
    assign push       = accept & ~fifo_full;
    assign pop        = rdy & ~fifo_empty;
    assign push_data  = {bus.in_rob_pc[TAG_LSB +: TAG_W], bus.in_rob_real_jump};

    bp_update_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (push_data),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // NOTE: next_state gets its default first so no path through the case infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (mispredict) next_state = FLUSH;
            FLUSH:   if (rdy)        next_state = IDLE;
            default:                 next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Everything below freezes while rdy is low, including a pending flush pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_bp_res         <= FALSE;
            bus.out_bp_tag         <= '0;
            bus.out_bp_jump_res    <= FALSE;
            bus.out_flush          <= FALSE;
            bus.out_redirect_pc    <= '0;
            bus.out_branch_cnt     <= '0;
            bus.out_mispredict_cnt <= '0;
        end else if (rdy) begin
            bus.out_bp_res <= pop;
            if (pop) {bus.out_bp_tag, bus.out_bp_jump_res} <= head;
            bus.out_flush <= mispredict;
            if (mispredict) begin
                bus.out_redirect_pc    <= bus.in_rob_target_pc;
                bus.out_mispredict_cnt <= bus.out_mispredict_cnt + 32'd1;
            end
            if (accept) bus.out_branch_cnt <= bus.out_branch_cnt + 32'd1;
        end
    end
endmodule

// File: doc/bp_update_unit.md
# bp_update_unit

Commit-side driver of the branch predictor's training port. It sits between the ROB commit stage and the 2-bit-counter predictor. It turns each committed branch into exactly one predictor update, buffered in a small FIFO. On a committed misprediction it raises a one-cycle pipeline flush with the redirect PC, and it keeps branch and mispredict statistics.

## Interface
- FIFO_DEPTH, 4: update FIFO entries (power of two, ≥2)
- TAG_W, 8: predictor index width
- TAG_LSB, 2: lowest PC bit used for the tag; tag = pc[TAG_LSB+TAG_W-1:TAG_LSB]
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; when low, all state holds
- in_rob_commit_valid  in  1  ROB commits an entry this cycle
- in_rob_is_branch  in  1  committed entry is a conditional branch
- in_rob_pc  in  32  PC of committed entry
- in_rob_pred_jump  in  1  direction predicted at fetch
- in_rob_real_jump  in  1  resolved direction
- in_rob_target_pc  in  32  correct next PC (taken target or pc+4)
- out_rob_stall  out  1  ROB must not commit this cycle
- out_bp_res  out  1  predictor update valid
- out_bp_tag  out  TAG_W  predictor index to update
- out_bp_jump_res  out  1  resolved direction for the update
- out_flush  out  1  flush all speculative state
- out_redirect_pc  out  32  fetch restart PC, valid with out_flush
- out_branch_cnt  out  32  committed branches
- out_mispredict_cnt  out  32  committed mispredictions

## Operation
- Accept = rdy & in_rob_commit_valid & in_rob_is_branch & ~out_rob_stall.
- On accept: push {tag, real_jump} into the FIFO and increment out_branch_cnt.
- If also pred_jump != real_jump: increment out_mispredict_cnt, latch in_rob_target_pc, go to FLUSH.
- Non-branch commits are ignored; they are never stalled unless the stall condition holds.
- FSM states:
  - IDLE: transitions to FLUSH on a mispredicted accept.
  - FLUSH: out_flush=1 and out_redirect_pc=latched target for exactly one cycle, then IDLE unconditionally (when rdy).
- out_rob_stall = (count == FIFO_DEPTH) | (state == FLUSH).
- Drain:
  - Each rdy edge with count > 0 pops the head into the output registers and sets out_bp_res=1.
  - Otherwise out_bp_res=0. out_bp_tag and out_bp_jump_res hold their last value.
- Push and pop in the same edge are legal; count is unchanged.
- Pushing when full is impossible by construction; the bench asserts it.
- A flush does not discard FIFO contents. Committed branches still train the predictor.
- Counters wrap modulo 2^32.
- rdy low: no push, no pop, FSM and all outputs hold (including a pending out_flush).
- Reset values:
  - FIFO empty, pointers 0, state IDLE.
  - out_bp_res=0, out_bp_tag=0, out_bp_jump_res=0.
  - out_flush=0, out_redirect_pc=0, both counters 0.
  - out_rob_stall=0.
- Reset mid-flush or with a non-empty FIFO discards everything; there is no update or flush after reset.

## Timing
- All outputs are registered except out_rob_stall, which is combinational from count and state.
- Update latency: a branch accepted at edge t into an empty FIFO produces out_bp_res=1 during the cycle after edge t+1. There is no bypass.
- Each entry yields exactly one out_bp_res cycle; back-to-back entries give consecutive pulses.
- Mispredict accepted at edge t: out_flush=1 during the cycle after edge t. out_rob_stall is high in that same cycle.
- Counters are visible the cycle after the accepting edge.
- Pointer wrap: pointers are log2(FIFO_DEPTH) bits. count is log2(FIFO_DEPTH)+1 bits.

## Structure
- Shared definitions header: TRUE/FALSE, state encodings IDLE/FLUSH, default TAG_W.
- One natural sub-module: bp_update_fifo. It is a parameterised synchronous FIFO with push, pop, full, empty and count. The FSM, counters and output registers stay in the top.

## Test plan
- Single taken branch, pc=0x0000_1008, pred=1, real=1:
  - out_bp_res=1 for one cycle, two edges after accept, tag=0x02, jump_res=1.
  - No flush. branch_cnt=1, mispredict_cnt=0.
- Mispredict, pc=0x0000_0400, pred=1, real=0, target=0x0000_0404:
  - out_flush=1 for one cycle with redirect=0x0000_0404, stall high in that cycle.
  - Update tag=0x00, jump_res=0. mispredict_cnt=1.
- Five branches on consecutive cycles:
  - out_rob_stall rises when count reaches 4.
  - All five updates appear in order with no loss or duplication.
- rdy low for 3 cycles while the FIFO holds 2 entries and out_flush=1:
  - All outputs frozen, then resume with one flush cycle and two update pulses.
- rst asserted during FLUSH with 3 queued entries:
  - Next cycle all outputs 0, and no update pulses after rst deasserts.
- Non-branch commits interleaved with branches:
  - Only branches produce updates. branch_cnt equals the number of branches.
